// File: rtl/traffic_pkg.sv
// Shared phase codes, widths and control-FSM encoding for the traffic phase
// sequencer and the duration table it reads.
package traffic_pkg;

  localparam int STATE_W = 3;
  localparam int DUR_W   = 5;

  localparam logic [STATE_W-1:0] ST_RED    = 3'b001;
  localparam logic [STATE_W-1:0] ST_YELLOW = 3'b010;
  localparam logic [STATE_W-1:0] ST_GREEN  = 3'b100;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fsm_e;

  // Phase rotation RED -> GREEN -> YELLOW -> RED; anything else recovers to RED.
  function automatic logic [STATE_W-1:0] next_phase(input logic [STATE_W-1:0] s);
    case (s)
      ST_RED:    next_phase = ST_GREEN;
      ST_GREEN:  next_phase = ST_YELLOW;
      ST_YELLOW: next_phase = ST_RED;
      default:   next_phase = ST_RED;
    endcase
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while en is low and is zeroed by clear.
module tick_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = en && !clear && (cnt_q == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Owns the current traffic phase: loads its duration from the table, counts it
// down on 1 s ticks and advances RED -> GREEN -> YELLOW; zero duration halts.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DUR_W-1:0]   fintime,
  output logic [STATE_W-1:0] state,
  output logic [DUR_W-1:0]   remaining,
  output logic               phase_done,
  output logic               fault
);

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [DUR_W-1:0]   remaining_q, remaining_d;
  logic               phase_done_q, phase_done_d;
  logic               fault_q, fault_d;
  logic               tick;
  logic               state_legal;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (fsm_q != RUN),
    .en    (enable && (fsm_q == RUN)),
    .tick  (tick)
  );

  assign state_legal = (state_q == ST_RED) || (state_q == ST_YELLOW) || (state_q == ST_GREEN);

  always_comb begin
    fsm_d        = fsm_q;
    state_d      = state_q;
    remaining_d  = remaining_q;
    phase_done_d = 1'b0;
    fault_d      = fault_q;
    if (!state_legal) begin
      fsm_d       = LOAD;
      state_d     = ST_RED;
      remaining_d = '0;
    end else begin
      case (fsm_q)
        LOAD: begin
          if (fintime != '0) begin
            remaining_d = fintime;
            fsm_d       = RUN;
          end else begin
            fault_d     = 1'b1;
            state_d     = ST_RED;
            remaining_d = '0;
            fsm_d       = HALT;
          end
        end
        RUN: begin
          if (tick) begin
            // remaining of 0 cannot occur in RUN; treat it like the last second.
            if (remaining_q > DUR_W'(1)) begin
              remaining_d = remaining_q - 1'b1;
            end else begin
              remaining_d  = '0;
              phase_done_d = 1'b1;
              state_d      = next_phase(state_q);
              fsm_d        = LOAD;
            end
          end
        end
        HALT: begin
          state_d     = ST_RED;
          remaining_d = '0;
        end
        default: begin
          fsm_d       = LOAD;
          state_d     = ST_RED;
          remaining_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q        <= LOAD;
      state_q      <= ST_RED;
      remaining_q  <= '0;
      phase_done_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      phase_done_q <= phase_done_d;
      fault_q      <= fault_d;
    end
  end

  assign state      = state_q;
  assign remaining  = remaining_q;
  assign phase_done = phase_done_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: one instance at TICK_DIV=4 with a
// 10/25/20 duration stub, one at TICK_DIV=1 with 1 s phases.
module tb_traffic_phase_sequencer;
  import traffic_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n_a, en_a;
  logic [DUR_W-1:0]   fin_a;
  logic [STATE_W-1:0] state_a;
  logic [DUR_W-1:0]   rem_a;
  logic               done_a, fault_a;
  logic [DUR_W-1:0]   red_dur, green_dur, yellow_dur;

  logic               rst_n_b, en_b;
  logic [DUR_W-1:0]   fin_b;
  logic [STATE_W-1:0] state_b;
  logic [DUR_W-1:0]   rem_b;
  logic               done_b, fault_b;

  always_comb begin
    fin_a = '0;
    case (state_a)
      ST_RED:    fin_a = red_dur;
      ST_GREEN:  fin_a = green_dur;
      ST_YELLOW: fin_a = yellow_dur;
      default:   fin_a = '0;
    endcase
  end

  assign fin_b = 5'd1;

  traffic_phase_sequencer #(.TICK_DIV(4)) dut_a (
    .clk(clk), .rst_n(rst_n_a), .enable(en_a), .fintime(fin_a),
    .state(state_a), .remaining(rem_a), .phase_done(done_a), .fault(fault_a)
  );

  traffic_phase_sequencer #(.TICK_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n_b), .enable(en_b), .fintime(fin_b),
    .state(state_b), .remaining(rem_b), .phase_done(done_b), .fault(fault_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after edge 1 (the first LOAD) of instance A.
  task automatic restart_a();
    rst_n_a = 1'b0;
    step();
    rst_n_a = 1'b1;
    step();
  endtask

  int pulses, first_done, bad, exp_state;

  initial begin
    rst_n_a = 1'b0; en_a = 1'b1;
    red_dur = 5'd10; green_dur = 5'd25; yellow_dur = 5'd20;
    rst_n_b = 1'b0; en_b = 1'b1;
    step(); step();
    check_eq("rst_state", state_a, 1);
    check_eq("rst_rem", rem_a, 0);
    check_eq("rst_done", done_a, 0);
    check_eq("rst_fault", fault_a, 0);

    // Full loop: pulses at edges 41, 142, 223.
    rst_n_a = 1'b1;
    step();
    check_eq("load_rem", rem_a, 10);
    check_eq("load_state", state_a, 1);
    pulses = 0;
    for (int e = 2; e <= 223; e++) begin
      step();
      if (done_a) pulses++;
      if (e == 4)   check_eq("rem_e4", rem_a, 10);
      if (e == 5)   check_eq("rem_e5", rem_a, 9);
      if (e == 40)  check_eq("done_e40", done_a, 0);
      if (e == 41)  begin check_eq("done_e41", done_a, 1); check_eq("state_e41", state_a, 4); check_eq("rem_e41", rem_a, 0); end
      if (e == 42)  begin check_eq("rem_e42", rem_a, 25); check_eq("done_e42", done_a, 0); end
      if (e == 142) begin check_eq("done_e142", done_a, 1); check_eq("state_e142", state_a, 2); end
      if (e == 143) check_eq("rem_e143", rem_a, 20);
      if (e == 223) begin check_eq("done_e223", done_a, 1); check_eq("state_e223", state_a, 1); end
    end
    check_eq("loop_pulses", pulses, 3);

    // Freeze mid-count at remaining=6 for 7 edges; RED stretches to 48.
    restart_a();
    for (int e = 2; e <= 19; e++) step();
    check_eq("pre_hold_rem", rem_a, 6);
    en_a = 1'b0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (rem_a != 5'd6 || state_a != ST_RED || done_a) bad++;
    end
    check_eq("hold_bad", bad, 0);
    en_a = 1'b1;
    first_done = 0;
    for (int e = 27; e <= 60; e++) begin
      step();
      if (done_a && first_done == 0) first_done = e;
    end
    check_eq("hold_red_end", first_done, 48);

    // fintime changes during RUN are ignored.
    restart_a();
    step();
    red_dur = 5'd3;
    first_done = 0;
    for (int e = 3; e <= 45; e++) begin
      step();
      if (done_a && first_done == 0) first_done = e;
    end
    check_eq("fin_change_red_end", first_done, 41);
    red_dur = 5'd10;

    // Zero GREEN duration -> sticky fault, halted at RED.
    green_dur = 5'd0;
    restart_a();
    for (int e = 2; e <= 42; e++) begin
      step();
      if (e == 41) check_eq("z_done_e41", done_a, 1);
    end
    check_eq("z_fault", fault_a, 1);
    check_eq("z_state", state_a, 1);
    check_eq("z_rem", rem_a, 0);
    pulses = 0; bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (done_a) pulses++;
      if (state_a != ST_RED || rem_a != 5'd0 || !fault_a) bad++;
    end
    check_eq("z_pulses", pulses, 0);
    check_eq("z_halt_bad", bad, 0);
    green_dur = 5'd25;
    rst_n_a = 1'b0;
    step();
    check_eq("z_rst_fault", fault_a, 0);
    check_eq("z_rst_state", state_a, 1);

    // Reset mid-YELLOW at remaining=9 (edge 187).
    rst_n_a = 1'b1;
    step();
    for (int e = 2; e <= 187; e++) step();
    check_eq("y_state", state_a, 2);
    check_eq("y_rem", rem_a, 9);
    rst_n_a = 1'b0;
    step();
    check_eq("yr_state", state_a, 1);
    check_eq("yr_rem", rem_a, 0);
    check_eq("yr_done", done_a, 0);
    rst_n_a = 1'b1;
    step();
    check_eq("yr_reload", rem_a, 10);

    // TICK_DIV=1, 1 s phases: pulse every other edge, rotating states.
    check_eq("b_rst_state", state_b, 1);
    rst_n_b = 1'b1;
    step();
    check_eq("b_load_rem", rem_b, 1);
    check_eq("b_load_done", done_b, 0);
    for (int e = 2; e <= 13; e++) begin
      step();
      case ((e / 2) % 3)
        0:       exp_state = 1;
        1:       exp_state = 4;
        default: exp_state = 2;
      endcase
      check_eq("b_done", done_b, (e % 2 == 0) ? 1 : 0);
      check_eq("b_state", state_b, exp_state);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Sequential controller that owns the current traffic-light phase and times it. Drives the one-hot phase code into the duration lookup and reads back the phase duration in seconds. Counts that duration down against a 1 s tick, then advances RED → GREEN → YELLOW → RED. It is the consumer of the duration table and sits between that table and the lamp drivers.

## Interface
Parameters:
- TICK_DIV, default 50_000_000: clock cycles per 1 s tick; legal range ≥ 1 (1 = tick every cycle).

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all state changes on its rising edge
- rst_n  in  1  synchronous active-low reset
- enable  in  1  high = countdown runs; low = freeze prescaler and countdown
- fintime  in  5  phase duration in seconds, returned combinationally by the duration table for the current `state`
- state  out  3  one-hot phase: 3'b001 RED, 3'b010 YELLOW, 3'b100 GREEN; feeds the duration table
- remaining  out  5  seconds left in the current phase
- phase_done  out  1  one-cycle pulse on the cycle the phase advances
- fault  out  1  sticky; set when a zero duration is loaded

## Operation
- Control FSM states: LOAD, RUN, HALT.
- Reset (rst_n=0 at an edge):
  - state=3'b001, remaining=0, phase_done=0, fault=0, FSM=LOAD, prescaler=0.
  - Applies from any FSM state, mid-phase included.
- LOAD (exactly one cycle; not gated by enable):
  - Samples fintime. Clears prescaler.
  - If fintime≠0: remaining←fintime, FSM→RUN.
  - If fintime=0: fault←1, state←3'b001, remaining←0, FSM→HALT.
- RUN:
  - Prescaler counts only while enable=1 and raises tick when count=TICK_DIV-1 (count then wraps to 0).
  - On tick with remaining>1: remaining←remaining-1.
  - On tick with remaining=1: remaining←0, phase_done←1 for that cycle, state advances (001→100, 100→010, 010→001), FSM→LOAD.
  - fintime changes during RUN are ignored.
- HALT: fail-safe. state held at RED, remaining=0, no pulses. Exit only via reset.
- enable=0: prescaler count, remaining and state hold. When enable returns, counting resumes from the held prescaler value.
- Illegal state or FSM encoding: next edge forces state=3'b001 and FSM=LOAD.
- Outputs: all registered. state is always a legal one-hot value.

## Timing
- First LOAD is the first edge with rst_n=1. remaining equals fintime after that edge.
- Phase of N seconds with enable held high: 1 LOAD cycle + N·TICK_DIV RUN cycles.
  - phase_done is high during the final RUN cycle's output, i.e. after the edge that advances state.
  - The new state is visible in the same cycle as phase_done. The next edge is the LOAD of the new phase.
- Latency from state change to new remaining loaded: 1 edge.
- Table values RED 10, GREEN 25, YELLOW 20 with TICK_DIV=4 give phase lengths 41/101/81 cycles; full loop 223 cycles.
- Reset and tick on the same edge: reset wins.

## Structure
- Shared package traffic_pkg holds:
  - ST_RED=3'b001, ST_YELLOW=3'b010, ST_GREEN=3'b100
  - STATE_W=3, DUR_W=5
  - control-FSM encoding LOAD/RUN/HALT
- The duration table already uses the same state codes. Both blocks import the package.
- Sub-module tick_prescaler:
  - Parameter: TICK_DIV.
  - Inputs: clk, rst_n, clear, en. Output: tick.
  - Counter width $clog2(TICK_DIV) with a minimum of 1.
- Sequencer holds the FSM, state register, remaining counter and pulse/fault logic.

## Test plan
- Reset, TICK_DIV=4, table stub 10/25/20, enable=1 → remaining=10 after first edge. RED lasts 41 cycles, GREEN 101, YELLOW 81. phase_done pulses exactly at 41, 142, 223. Sequence 001→100→010→001.
- enable dropped for 7 cycles mid-RED at remaining=6 → remaining stays 6, state stays 001 for those 7 cycles. Total RED length becomes 48 cycles.
- Stub returns 0 for GREEN → on GREEN's LOAD edge fault=1, state=001, remaining=0. No further phase_done for 50 cycles. Reset clears fault.
- rst_n low for one edge in mid-YELLOW (remaining=9) → next cycle state=001, remaining=0, phase_done=0. Following edge loads remaining=10.
- TICK_DIV=1, durations 1/1/1 → phase_done every 2 cycles, states rotate 001→100→010 continuously.
- fintime changed to 3 during RED RUN → RED still lasts its originally loaded duration.
